// File: rtl/op_unit_exerciser_if.sv
// Operand/result bus between the self-test exerciser and the 4-bit operator
// unit, plus the byte stream that carries captured result records out.
interface op_unit_exerciser_if;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [3:0] op_c;
  logic [3:0] op_d;
  logic [3:0] res_arith;
  logic [3:0] res_shift;
  logic [3:0] res_bitwise;
  logic [3:0] res_concat;
  logic [3:0] res_cond;
  logic       res_rel;
  logic       res_eq;
  logic       res_red;
  logic       res_logical;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  // Exerciser side: drives operands and the byte stream.
  modport master (
    output op_a, op_b, op_c, op_d,
    input  res_arith, res_shift, res_bitwise, res_concat, res_cond,
    input  res_rel, res_eq, res_red, res_logical,
    output tx_data, tx_valid,
    input  tx_ready
  );

  // Operator unit / byte sink side.
  modport slave (
    input  op_a, op_b, op_c, op_d,
    output res_arith, res_shift, res_bitwise, res_concat, res_cond,
    output res_rel, res_eq, res_red, res_logical,
    input  tx_data, tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/op_unit_exerciser.sv
// Self-test driver/checker for the 4-bit operator unit. Operands come from a
// 16-bit Fibonacci LFSR; each result set is checked against a golden model and
// streamed out as three bytes over a valid/ready interface.
module op_unit_exerciser #(
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          NUM_VECTORS = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  op_unit_exerciser_if.master        bus,
  output logic                       busy,
  output logic                       done,
  output logic [7:0]                 err_count,
  output logic                       err_seen,
  output logic [7:0]                 first_err_idx
);

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [7:0]  LAST_IDX = 8'(NUM_VECTORS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DRIVE, S_SEND0, S_SEND1, S_SEND2, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] ops;
  logic [15:0] lfsr;
  logic [7:0]  vec_cnt;
  logic [23:0] rec;
  logic [23:0] res_rec;
  logic        start_acc;
  logic        step;
  logic        tx_valid_c;
  logic [7:0]  tx_data_c;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Expected record, laid out exactly as the three transmitted bytes.
  function automatic logic [23:0] golden(input logic [15:0] o);
    logic [3:0] a, b, c, d;
    logic       rel;
    a   = o[15:12];
    b   = o[11:8];
    c   = o[7:4];
    d   = o[3:0];
    rel = (a > b);
    // b >> c already yields 0 for any c >= 4 on a 4-bit operand.
    return {b + c, b >> c, a & b, c[1:0], d[3:2],
            rel ? a : b, rel, a == d, |b, rel || (a > d)};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign res_rec = {bus.res_arith, bus.res_shift, bus.res_bitwise, bus.res_concat,
                    bus.res_cond, bus.res_rel, bus.res_eq, bus.res_red,
                    bus.res_logical};

  assign bus.op_a     = ops[15:12];
  assign bus.op_b     = ops[11:8];
  assign bus.op_c     = ops[7:4];
  assign bus.op_d     = ops[3:0];
  assign bus.tx_valid = tx_valid_c;
  assign bus.tx_data  = tx_data_c;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and state-decoded outputs; tx_valid depends on state only.
  always_comb begin
    state_nxt  = state;
    tx_valid_c = 1'b0;
    tx_data_c  = 8'h00;
    busy       = 1'b0;
    done       = 1'b0;
    start_acc  = 1'b0;
    step       = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        done = (state == S_DONE);
        if (start) begin
          start_acc = 1'b1;
          state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        busy      = 1'b1;
        state_nxt = S_SEND0;
      end
      S_SEND0: begin
        busy       = 1'b1;
        tx_valid_c = 1'b1;
        tx_data_c  = rec[23:16];
        if (bus.tx_ready) state_nxt = S_SEND1;
      end
      S_SEND1: begin
        busy       = 1'b1;
        tx_valid_c = 1'b1;
        tx_data_c  = rec[15:8];
        if (bus.tx_ready) state_nxt = S_SEND2;
      end
      S_SEND2: begin
        busy       = 1'b1;
        tx_valid_c = 1'b1;
        tx_data_c  = rec[7:0];
        if (bus.tx_ready) begin
          if (vec_cnt == LAST_IDX) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_DRIVE;
            step      = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand generation, result capture and mismatch bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops           <= 16'h0000;
      lfsr          <= SEED_EFF;
      vec_cnt       <= 8'h00;
      rec           <= 24'h000000;
      err_count     <= 8'h00;
      err_seen      <= 1'b0;
      first_err_idx <= 8'h00;
    end else if (start_acc) begin
      ops           <= SEED_EFF;
      lfsr          <= SEED_EFF;
      vec_cnt       <= 8'h00;
      err_count     <= 8'h00;
      err_seen      <= 1'b0;
      first_err_idx <= 8'h00;
    end else if (state == S_DRIVE) begin
      rec <= res_rec;
      if (res_rec != golden(ops)) begin
        err_count <= sat_inc(err_count);
        if (!err_seen) begin
          err_seen      <= 1'b1;
          first_err_idx <= vec_cnt;
        end
      end
    end else if (step) begin
      lfsr    <= lfsr_step(lfsr);
      ops     <= lfsr_step(lfsr);
      vec_cnt <= vec_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_op_unit_exerciser.sv
// Directed bench for op_unit_exerciser: a golden operator unit is attached to
// each instance, result bytes are collected and compared with expected values.
module tb_op_unit_exerciser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start1, start2, fault1;
  logic       busy1, done1, err_seen1, busy2, done2, err_seen2;
  logic [7:0] err_count1, first_err_idx1, err_count2, first_err_idx2;

  op_unit_exerciser_if if1 ();
  op_unit_exerciser_if if2 ();

  op_unit_exerciser #(.SEED(16'hACE1), .NUM_VECTORS(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bus(if1),
    .busy(busy1), .done(done1), .err_count(err_count1),
    .err_seen(err_seen1), .first_err_idx(first_err_idx1)
  );

  op_unit_exerciser #(.SEED(16'h0000), .NUM_VECTORS(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bus(if2),
    .busy(busy2), .done(done2), .err_count(err_count2),
    .err_seen(err_seen2), .first_err_idx(first_err_idx2)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] got  [0:31];
  logic [7:0] expb [0:31];

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Reference operator unit, record laid out as the three result bytes.
  function automatic logic [23:0] gold(input logic [15:0] l);
    int a, b, c, d, ar, sh, bw, cc, cd;
    bit rel, eq, red, lg;
    a   = int'(l[15:12]);
    b   = int'(l[11:8]);
    c   = int'(l[7:4]);
    d   = int'(l[3:0]);
    ar  = (b + c) % 16;
    sh  = (c >= 4) ? 0 : (b >> c);
    bw  = a & b;
    cc  = (c % 4) * 4 + d / 4;
    rel = (a > b);
    cd  = rel ? a : b;
    eq  = (a == d);
    red = (b != 0);
    lg  = rel || (a > d);
    return {ar[3:0], sh[3:0], bw[3:0], cc[3:0], cd[3:0], rel, eq, red, lg};
  endfunction

  logic [23:0] g1, g2;
  assign g1 = gold({if1.op_a, if1.op_b, if1.op_c, if1.op_d});
  assign g2 = gold({if2.op_a, if2.op_b, if2.op_c, if2.op_d});

  assign if1.res_arith   = g1[23:20];
  assign if1.res_shift   = g1[19:16];
  assign if1.res_bitwise = g1[15:12];
  assign if1.res_concat  = g1[11:8];
  assign if1.res_cond    = g1[7:4];
  assign if1.res_rel     = g1[3];
  assign if1.res_eq      = g1[2] | fault1;
  assign if1.res_red     = g1[1];
  assign if1.res_logical = g1[0];

  assign if2.res_arith   = g2[23:20];
  assign if2.res_shift   = g2[19:16];
  assign if2.res_bitwise = g2[15:12];
  assign if2.res_concat  = g2[11:8];
  assign if2.res_cond    = g2[7:4];
  assign if2.res_rel     = g2[3];
  assign if2.res_eq      = g2[2];
  assign if2.res_red     = g2[1];
  assign if2.res_logical = g2[0];

  task automatic build_exp(input logic [15:0] seed, input int n);
    logic [15:0] l;
    logic [23:0] g;
    l = seed;
    for (int v = 0; v < n; v++) begin
      g = gold(l);
      expb[3*v]   = g[23:16];
      expb[3*v+1] = g[15:8];
      expb[3*v+2] = g[7:0];
      l = lfsr_next(l);
    end
  endtask

  function automatic int count_a_ne_d(input logic [15:0] seed, input int n);
    logic [15:0] l;
    int cnt;
    l = seed;
    cnt = 0;
    for (int v = 0; v < n; v++) begin
      if (l[15:12] != l[3:0]) cnt++;
      l = lfsr_next(l);
    end
    return cnt;
  endfunction

  task automatic pulse_start(input int which);
    if (which == 2) start2 = 1'b1;
    else            start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // Cycle numbering: cycle 1 is the cycle right after the start edge.
  task automatic collect(input int which, input int nb0, input int cyc0,
                         output int nb, output int done_cyc, output int first_vld);
    int cyc;
    logic v, r, d;
    logic [7:0] dat;
    nb = nb0;
    cyc = cyc0;
    done_cyc = -1;
    first_vld = -1;
    while (cyc < 300) begin
      v   = (which == 2) ? if2.tx_valid : if1.tx_valid;
      r   = (which == 2) ? if2.tx_ready : if1.tx_ready;
      dat = (which == 2) ? if2.tx_data  : if1.tx_data;
      d   = (which == 2) ? done2 : done1;
      if (d) begin
        done_cyc = cyc;
        break;
      end
      if (v && first_vld < 0) first_vld = cyc;
      if (v && r && nb < 32) begin
        got[nb] = dat;
        nb++;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic check_stream(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got[i] !== expb[i]) begin
        errors++;
        $display("FAIL %s byte %0d: got %h expected %h", name, i, got[i], expb[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; fault1 = 1'b0;
    if1.tx_ready = 1'b0; if2.tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({if1.tx_valid, busy1, done1, err_seen1} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000", {if1.tx_valid, busy1, done1, err_seen1});
    end
    checks++;
    if ({if1.op_a, if1.op_b, if1.op_c, if1.op_d, err_count1, first_err_idx1, if1.tx_data} !== 40'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {if1.op_a, if1.op_b, if1.op_c, if1.op_d,
               err_count1, first_err_idx1, if1.tx_data});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    int nb, dc, fv;
    if1.tx_ready = 1'b1;
    pulse_start(1);
    checks++;
    if ({if1.op_a, if1.op_b, if1.op_c, if1.op_d} !== 16'hACE1) begin
      errors++;
      $display("FAIL stream_ops: got %h expected ace1", {if1.op_a, if1.op_b, if1.op_c, if1.op_d});
    end
    collect(1, 0, 1, nb, dc, fv);
    checks++;
    if (fv !== 2) begin errors++; $display("FAIL stream_first_valid: got %0d expected 2", fv); end
    checks++;
    if (nb !== 12) begin errors++; $display("FAIL stream_nbytes: got %0d expected 12", nb); end
    checks++;
    if ({got[0], got[1], got[2]} !== 24'hA088C3) begin
      errors++;
      $display("FAIL stream_vec0: got %h expected a088c3", {got[0], got[1], got[2]});
    end
    check_stream("stream", 12);
    checks++;
    if (dc !== 17) begin errors++; $display("FAIL stream_done_cycle: got %0d expected 17", dc); end
    checks++;
    if ({err_count1, err_seen1, busy1} !== 10'b0) begin
      errors++;
      $display("FAIL stream_err: got %h/%b/%b expected 0/0/0", err_count1, err_seen1, busy1);
    end
  endtask

  task automatic test_backpressure();
    int nb, dc, fv;
    nb = 0;
    pulse_start(1);
    @(posedge clk); #1;
    if (if1.tx_valid && if1.tx_ready) begin got[0] = if1.tx_data; nb = 1; end
    @(posedge clk); #1;
    if1.tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({if1.tx_valid, if1.tx_data} !== 9'h188) begin
        errors++;
        $display("FAIL bp_hold %0d: got %h expected 188", k, {if1.tx_valid, if1.tx_data});
      end
      @(posedge clk); #1;
    end
    if1.tx_ready = 1'b1;
    collect(1, nb, 8, nb, dc, fv);
    checks++;
    if (nb !== 12) begin errors++; $display("FAIL bp_nbytes: got %0d expected 12", nb); end
    check_stream("bp", 12);
    checks++;
    if (dc !== 22) begin errors++; $display("FAIL bp_done_cycle: got %0d expected 22", dc); end
  endtask

  task automatic test_start_ignored();
    int nb, dc, fv;
    nb = 0;
    pulse_start(1);
    @(posedge clk); #1;
    if (if1.tx_valid && if1.tx_ready) begin got[0] = if1.tx_data; nb = 1; end
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    collect(1, nb, 3, nb, dc, fv);
    checks++;
    if (nb !== 12) begin errors++; $display("FAIL ign_nbytes: got %0d expected 12", nb); end
    check_stream("ign", 12);
    checks++;
    if (dc !== 17) begin errors++; $display("FAIL ign_done_cycle: got %0d expected 17", dc); end
  endtask

  task automatic test_fault();
    int nb, dc, fv;
    fault1 = 1'b1;
    pulse_start(1);
    collect(1, 0, 1, nb, dc, fv);
    checks++;
    if ({err_seen1, first_err_idx1} !== 9'h100) begin
      errors++;
      $display("FAIL fault_first: got %b/%0d expected 1/0", err_seen1, first_err_idx1);
    end
    checks++;
    if (int'(err_count1) !== count_a_ne_d(16'hACE1, 4)) begin
      errors++;
      $display("FAIL fault_count: got %0d expected %0d", err_count1, count_a_ne_d(16'hACE1, 4));
    end
    checks++;
    if (got[2] !== 8'hC7) begin
      errors++;
      $display("FAIL fault_captured_byte: got %h expected c7", got[2]);
    end
  endtask

  task automatic test_restart_clears();
    int nb, dc, fv;
    fault1 = 1'b0;
    pulse_start(1);
    checks++;
    if ({done1, err_seen1, err_count1, first_err_idx1} !== 18'h0) begin
      errors++;
      $display("FAIL restart_clear: got %b/%b/%0d/%0d expected 0/0/0/0",
               done1, err_seen1, err_count1, first_err_idx1);
    end
    collect(1, 0, 1, nb, dc, fv);
    checks++;
    if (got[0] !== 8'hA0) begin errors++; $display("FAIL restart_first_byte: got %h expected a0", got[0]); end
    checks++;
    if (nb !== 12 || err_count1 !== 8'h00) begin
      errors++;
      $display("FAIL restart_run: got %0d bytes/%0d errs expected 12/0", nb, err_count1);
    end
  endtask

  task automatic test_reset_midrun();
    int nb, dc, fv;
    fault1 = 1'b1;
    pulse_start(1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({if1.tx_valid, if1.tx_data, err_count1} !== 17'h18801) begin
      errors++;
      $display("FAIL mid_pre: got %h expected 18801", {if1.tx_valid, if1.tx_data, err_count1});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({if1.tx_valid, busy1, done1, err_seen1, err_count1, if1.tx_data} !== 20'h0) begin
      errors++;
      $display("FAIL mid_reset_ctrl: got %h expected 0",
               {if1.tx_valid, busy1, done1, err_seen1, err_count1, if1.tx_data});
    end
    checks++;
    if ({if1.op_a, if1.op_b, if1.op_c, if1.op_d} !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset_ops: got %h expected 0", {if1.op_a, if1.op_b, if1.op_c, if1.op_d});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    fault1 = 1'b0;
    @(posedge clk); #1;
    pulse_start(1);
    collect(1, 0, 1, nb, dc, fv);
    checks++;
    if (nb !== 12 || dc !== 17) begin
      errors++;
      $display("FAIL mid_replay_len: got %0d bytes/cycle %0d expected 12/17", nb, dc);
    end
    check_stream("mid_replay", 12);
  endtask

  task automatic test_seed_zero();
    int nb, dc, fv;
    if2.tx_ready = 1'b1;
    pulse_start(2);
    checks++;
    if ({if2.op_a, if2.op_b, if2.op_c, if2.op_d} !== 16'h0001) begin
      errors++;
      $display("FAIL seed0_ops: got %h expected 0001", {if2.op_a, if2.op_b, if2.op_c, if2.op_d});
    end
    collect(2, 0, 1, nb, dc, fv);
    checks++;
    if (nb !== 3) begin errors++; $display("FAIL seed0_nbytes: got %0d expected 3", nb); end
    checks++;
    if ({got[0], got[1], got[2]} !== 24'h000000) begin
      errors++;
      $display("FAIL seed0_bytes: got %h expected 000000", {got[0], got[1], got[2]});
    end
    checks++;
    if (dc !== 5 || err_count2 !== 8'h00) begin
      errors++;
      $display("FAIL seed0_done: got cycle %0d errs %0d expected 5/0", dc, err_count2);
    end
  endtask

  initial begin
    build_exp(16'hACE1, 4);
    test_reset();
    test_stream();
    test_backpressure();
    test_start_ignored();
    test_fault();
    test_restart_clears();
    test_reset_midrun();
    test_seed_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/op_unit_exerciser.md
Name: op_unit_exerciser

Overview:
Sequential driver/checker for the team's 4-bit combinational operator unit. It generates operand sets {A,B,C,D} from an LFSR and drives them into the unit. It captures the unit's nine result fields, checks them against an internal golden model, and streams each captured result record out as 3 bytes over a valid/ready byte interface. It sits on the operand/result side of the operator unit, in the self-test path.

Parameters:
SEED, 16'hACE1, LFSR load value on start; a value of 0 is replaced by 16'h0001.
NUM_VECTORS, 256, vectors per run; legal range 1..256.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle run request; accepted only in IDLE or DONE
op_a, op_b, op_c, op_d  out  4 each  operands to the operator unit; registered
res_arith  in  4  unit result for B+C
res_shift  in  4  unit result for B>>C
res_bitwise  in  4  unit result for A&B
res_concat  in  4  unit result for {C[1:0],D[3:2]}
res_cond  in  4  unit result for (A>B)?A:B
res_rel, res_eq, res_red, res_logical  in  1 each  unit results for A>B, A==D, |B, (A>B)||(A>D)
tx_data  out  8  result byte
tx_valid  out  1  tx_data is valid
tx_ready  in  1  sink accepts the byte
busy  out  1  run in progress
done  out  1  run complete; held until the next start
err_count  out  8  mismatch count; saturates at 255
err_seen  out  1  at least one mismatch this run
first_err_idx  out  8  index of the first mismatching vector; valid when err_seen=1

Behaviour:
- Reset (async, takes effect immediately, including mid-operation):
  - state=IDLE; op_*=0; tx_data=0; tx_valid=0; busy=0; done=0.
  - err_count=0; err_seen=0; first_err_idx=0; lfsr=SEED (or 1 if SEED=0); vec_cnt=0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Shift left; bit0 = l[15]^l[13]^l[12]^l[10].
- Operand mapping: op_a=l[15:12], op_b=l[11:8], op_c=l[7:4], op_d=l[3:0].
- States: IDLE, DRIVE, SEND0, SEND1, SEND2, DONE.
- IDLE/DONE + start:
  - Load lfsr=SEED and drive op_* from the SEED nibbles.
  - vec_cnt=0; clear err_count, err_seen, first_err_idx and done.
  - busy=1; go to DRIVE.
- start while busy is ignored.
- DRIVE lasts exactly 1 cycle. At its closing edge:
  - Capture all res_* into a record register.
  - Compare against the golden model computed from the registered op_*. Any field differing counts as one mismatch: err_count++ (saturating); on the first mismatch set err_seen=1 and first_err_idx=vec_cnt.
  - Go to SEND0.
- Golden model, all unsigned and truncated to 4 bits:
  - arith = (B+C) mod 16
  - shift = B>>C, which is 0 for C>=4
  - rel = A>B; eq = A==D; red = |B; logical = (A>B)||(A>D)
  - bitwise = A&B; concat = {C[1:0],D[3:2]}; cond = A>B ? A : B
- Byte packing:
  - SEND0: {arith, shift}
  - SEND1: {bitwise, concat}
  - SEND2: {cond, rel, eq, red, logical}, with logical in bit0.
- Handshake:
  - In SENDk, tx_valid=1 and tx_data is held stable until the edge where tx_valid&tx_ready; then advance state.
  - tx_valid has no combinational dependence on tx_ready.
  - tx_valid is deasserted in DRIVE, IDLE and DONE.
- After SEND2 is accepted:
  - If vec_cnt==NUM_VECTORS-1: go to DONE; busy=0; done=1 from the next cycle.
  - Else: step the LFSR, update op_* with the new value on the same edge, vec_cnt++, go to DRIVE.
- Timing with tx_ready held at 1:
  - First tx_valid appears 2 cycles after the start edge.
  - Each vector takes 4 cycles.
  - done rises 4*NUM_VECTORS+1 cycles after the start edge.
- vec_cnt is 8-bit; NUM_VECTORS=256 ends at vec_cnt=255 without wrap issues.

Test Plan:
1. Reset: assert rst_n=0 mid-run (in SEND1) -> tx_valid, busy, done, err_* and op_* go to 0 immediately, without waiting for a clock edge. After release, start replays a byte stream identical to the original from SEED.
2. Golden unit attached, NUM_VECTORS=4, tx_ready=1, start -> vector 0 has op_a=A, op_b=C, op_c=E, op_d=1. Bytes 0xA0, 0x88, 0xC3 follow, then 9 more bytes (12 total). done=1 at start+17 cycles; err_count=0; err_seen=0.
3. Backpressure: tx_ready=0 for 5 cycles while in SEND1 -> tx_valid stays 1 and tx_data stays 0x88. The byte transfers on the first edge with tx_ready=1; no byte is duplicated or dropped.
4. Fault injection: res_eq stuck at 1 -> err_seen=1 and first_err_idx=0 (vector 0 has A!=D). err_count equals the number of vectors with op_a!=op_d, per the model.
5. start pulsed during SEND0 -> ignored; run length and byte count unchanged.
6. start in DONE -> done clears the next cycle, err_* are cleared, and the stream restarts from SEED with 0xA0 first.
7. SEED=0, NUM_VECTORS=1 -> operands come from 16'h0001 (op_a=op_b=op_c=0, op_d=1). Exactly 3 bytes are sent, then done=1.
